// File: rtl/fpu_op_sequencer.sv
// Issue/capture stage around the FPU: accepts one operation, holds its operands on the FPU
// inputs for that opcode's fixed latency, captures the result and hands it to writeback.
// Every latency parameter must lie in 1..63 (the counter is 6 bits and loads LAT-1).
module fpu_op_sequencer #(
  parameter int unsigned ADDSUB_LAT = 7,
  parameter int unsigned MULT_LAT   = 5,
  parameter int unsigned DIV_LAT    = 28,
  parameter int unsigned FTOI_LAT   = 6,
  parameter int unsigned ITOF_LAT   = 6,
  parameter int unsigned SQRT_LAT   = 28
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  output logic        oReady,
  input  logic [2:0]  iOperation,
  input  logic [31:0] iSrc0,
  input  logic [31:0] iSrc1,
  input  logic [4:0]  iDestTag,
  output logic [31:0] oFpuSrc0,
  output logic [31:0] oFpuSrc1,
  output logic [2:0]  oFpuOperation,
  input  logic [31:0] iFpuResult,
  output logic        oValid,
  input  logic        iReady,
  output logic [31:0] oResult,
  output logic [4:0]  oDestTag,
  output logic        oIllegal
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} stateE;

  stateE       stateQ, stateD;
  logic [5:0]  cntQ, cntD;
  logic [31:0] src0Q, src0D, src1Q, src1D;
  logic [2:0]  opQ, opD;
  logic [4:0]  pendTagQ, pendTagD;
  logic [31:0] resultQ, resultD;
  logic [4:0]  tagQ, tagD;
  logic        illegalQ, illegalD;

  // Counter preload: latency minus one, so EXEC lasts exactly LAT cycles.
  function automatic logic [5:0] latMinus1(input logic [2:0] op);
    logic [5:0] v;
    case (op)
      3'b000, 3'b001: v = 6'(ADDSUB_LAT - 1);
      3'b010:         v = 6'(MULT_LAT - 1);
      3'b011:         v = 6'(DIV_LAT - 1);
      3'b100:         v = 6'(FTOI_LAT - 1);
      3'b101:         v = 6'(ITOF_LAT - 1);
      3'b110:         v = 6'(SQRT_LAT - 1);
      default:        v = 6'd0;
    endcase
    return v;
  endfunction

  // Next-state and handshake outputs.
  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    src0D    = src0Q;
    src1D    = src1Q;
    opD      = opQ;
    pendTagD = pendTagQ;
    resultD  = resultQ;
    tagD     = tagQ;
    illegalD = illegalQ;
    oReady   = 1'b0;
    oValid   = 1'b0;
    case (stateQ)
      StIdle: begin
        oReady = 1'b1;
        if (iValid) begin
          if (iOperation == 3'b111) begin
            // Illegal ops bypass the FPU, leaving its input registers untouched.
            resultD  = 32'd0;
            illegalD = 1'b1;
            tagD     = iDestTag;
            stateD   = StDone;
          end else begin
            src0D    = iSrc0;
            src1D    = iSrc1;
            opD      = iOperation;
            pendTagD = iDestTag;
            cntD     = latMinus1(iOperation);
            stateD   = StExec;
          end
        end
      end
      StExec: begin
        if (cntQ == 6'd0) begin
          resultD  = iFpuResult;
          illegalD = 1'b0;
          // Tag is published with the result so result outputs change together.
          tagD     = pendTagQ;
          stateD   = StDone;
        end else begin
          cntD = cntQ - 6'd1;
        end
      end
      StDone: begin
        oValid = 1'b1;
        if (iReady) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  // State register with synchronous reset; reset discards any in-flight operation.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateQ   <= StIdle;
      cntQ     <= 6'd0;
      src0Q    <= 32'd0;
      src1Q    <= 32'd0;
      opQ      <= 3'b000;
      pendTagQ <= 5'd0;
      resultQ  <= 32'd0;
      tagQ     <= 5'd0;
      illegalQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      src0Q    <= src0D;
      src1Q    <= src1D;
      opQ      <= opD;
      pendTagQ <= pendTagD;
      resultQ  <= resultD;
      tagQ     <= tagD;
      illegalQ <= illegalD;
    end
  end

  assign oFpuSrc0      = src0Q;
  assign oFpuSrc1      = src1Q;
  assign oFpuOperation = opQ;
  assign oResult       = resultQ;
  assign oDestTag      = tagQ;
  assign oIllegal      = illegalQ;

endmodule
